// File: rtl/puc_pkg.sv
// puc_pkg: shared opcode values, ROM word layout and fetch FSM state encoding
package puc_pkg;
    localparam logic [3:0] OP_HALT = 4'hF;
    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] operand;
    } rom_word_t;
    typedef enum logic [2:0] {FETCH, WAIT, ISSUE, HALT, SWITCH} state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous board inputs
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= '0;
        else     {q, meta} <= {meta, d};
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: feeds the ALU from block ROM (program mode) or board switches (switch mode)
module instr_fetch_unit
    import puc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int PROG_LEN    = 256,
    parameter int ROM_LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              select_input,
    input  logic [3:0]        in_switch,
    input  logic [7:0]        douta,
    output logic [ADDR_W-1:0] addra,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        instr_opcode,
    output logic [3:0]        instr_operand,
    output logic              halted
);
    localparam int CNT_W = ROM_LATENCY > 1 ? $clog2(ROM_LATENCY) : 1;
    logic              sel_s, xfer, valid, valid_n, halt_r, halt_n, sw_first, sw_first_n;
    logic [3:0]        sw_s, last_sw, last_sw_n, opc, opc_n, opr, opr_n;
    logic [ADDR_W-1:0] pc, pc_n, pc_inc;
    logic [CNT_W-1:0]  cnt, cnt_n;
    state_t            state, state_n;
    rom_word_t         word;
    sync2 #(.WIDTH(1)) u_sel (.clk(CLK), .rst(RESET), .d(select_input), .q(sel_s));
    sync2 #(.WIDTH(4)) u_sw  (.clk(CLK), .rst(RESET), .d(in_switch),    .q(sw_s));
    assign word          = douta;
    assign xfer          = valid & instr_ready;
    assign pc_inc        = pc == ADDR_W'(PROG_LEN - 1) ? '0 : pc + 1'b1;
    assign addra         = pc;
    assign instr_valid   = valid;
    assign instr_opcode  = opc;
    assign instr_operand = opr;
    // halted drops as soon as the synchronised mode leaves program mode
    assign halted        = halt_r & sel_s;
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            state    <= FETCH;
            pc       <= '0;
            cnt      <= '0;
            valid    <= 1'b0;
            opc      <= '0;
            opr      <= '0;
            halt_r   <= 1'b0;
            last_sw  <= '0;
            sw_first <= 1'b1;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            cnt      <= cnt_n;
            valid    <= valid_n;
            opc      <= opc_n;
            opr      <= opr_n;
            halt_r   <= halt_n;
            last_sw  <= last_sw_n;
            sw_first <= sw_first_n;
        end
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        cnt_n      = cnt;
        valid_n    = valid;
        opc_n      = opc;
        opr_n      = opr;
        halt_n     = halt_r;
        last_sw_n  = last_sw;
        sw_first_n = sw_first;
        case (state)
            FETCH, WAIT:
                if (!sel_s) begin
                    state_n    = SWITCH;
                    sw_first_n = 1'b1;
                end else if (state == FETCH) begin
                    cnt_n   = CNT_W'(ROM_LATENCY - 1);
                    state_n = WAIT;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (word.opcode == OP_HALT) begin
                    halt_n  = 1'b1;
                    state_n = HALT;
                end else begin
                    {opc_n, opr_n} = word;
                    valid_n        = 1'b1;
                    state_n        = ISSUE;
                end
            ISSUE:
                if (xfer) begin
                    valid_n    = 1'b0;
                    pc_n       = pc_inc;
                    state_n    = sel_s ? FETCH : SWITCH;
                    sw_first_n = 1'b1;
                end
            HALT:
                if (!sel_s) begin
                    halt_n     = 1'b0;
                    state_n    = SWITCH;
                    sw_first_n = 1'b1;
                end
            SWITCH:
                if (sel_s && (!valid || xfer)) begin
                    valid_n = 1'b0;
                    pc_n    = '0;
                    state_n = FETCH;
                end else if (xfer) begin
                    valid_n = 1'b0;
                end else if (!valid && (sw_s != last_sw || sw_first)) begin
                    valid_n    = 1'b1;
                    opc_n      = sw_s;
                    opr_n      = 4'h0;
                    last_sw_n  = sw_s;
                    sw_first_n = 1'b0;
                end
            default: state_n = FETCH;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench, directed program/switch/halt/wrap scenarios
module tb_instr_fetch_unit;
    logic       clk = 1'b0, rst = 1'b1, rst2 = 1'b1, sel = 1'b1, ready = 1'b0, rdy2 = 1'b1;
    logic [3:0] sw = 4'h0;
    logic [7:0] rom1 [256];
    logic [7:0] p1 = 8'h00, douta1 = 8'h00, addra1, addra2;
    logic [3:0] opc1, opr1, opc2, opr2;
    logic       v1, h1, v2, h2;
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    int         a2_log [$];
    int         c2_log [$];
    int         tests = 0, fails = 0, cyc = 0, xf1 = 0, xf2 = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(8), .PROG_LEN(256), .ROM_LATENCY(2)) dut (
        .CLK(clk), .RESET(rst), .select_input(sel), .in_switch(sw), .douta(douta1),
        .addra(addra1), .instr_valid(v1), .instr_ready(ready), .instr_opcode(opc1),
        .instr_operand(opr1), .halted(h1));

    instr_fetch_unit #(.ADDR_W(8), .PROG_LEN(4), .ROM_LATENCY(2)) dut2 (
        .CLK(clk), .RESET(rst2), .select_input(1'b1), .in_switch(4'h0), .douta(8'h11),
        .addra(addra2), .instr_valid(v2), .instr_ready(rdy2), .instr_opcode(opc2),
        .instr_operand(opr2), .halted(h2));

    // two-edge ROM read pipeline
    always @(posedge clk) begin
        p1     <= rom1[addra1];
        douta1 <= p1;
        cyc    <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (!rst && v1 && ready) begin
            xf1++;
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL xfer1_extra: got %h, required no transfer", {opc1, opr1});
            end else chk("xfer1_payload", {opc1, opr1}, q1.pop_front());
        end

    always @(negedge clk)
        if (!rst2 && v2 && rdy2) begin
            xf2++;
            a2_log.push_back(int'(addra2));
            c2_log.push_back(cyc);
            if (q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL xfer2_extra: got %h, required no transfer", {opc2, opr2});
            end else chk("xfer2_payload", {opc2, opr2}, q2.pop_front());
        end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        int n, x;
        int exp_a [6] = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 256; i++) rom1[i] = 8'h00;
        rom1[0] = 8'h12;
        rom1[1] = 8'h34;
        rom1[2] = 8'hF0;
        repeat (25) tick();
        chk("rst_addra", addra1, 0);
        chk("rst_valid", v1, 0);
        chk("rst_halted", h1, 0);
        // first release: sel_s is still low, so a switch word is offered first
        rst = 1'b0;
        n = 0;
        while (!v1 && n < 10) begin tick(); n++; end
        chk("startup_valid", v1, 1);
        chk("startup_payload", {opc1, opr1}, 8'h00);
        #2 rst = 1'b1;
        #1 chk("async_rst_valid", v1, 0);
        repeat (3) tick();
        ready = 1'b1;
        q1.push_back(8'h00);
        q1.push_back(8'h12);
        rst = 1'b0;
        n = 0;
        while (addra1 != 8'd1 && n < 30) begin tick(); n++; end
        chk("addra_reach_1", addra1, 1);
        ready = 1'b0;
        n = 0;
        while (!v1 && n < 10) begin tick(); n++; end
        chk("addra_to_valid_edges", n, 3);
        repeat (10) begin
            tick();
            chk("stall_valid", v1, 1);
            chk("stall_payload", {opc1, opr1}, 8'h34);
            chk("stall_addra", addra1, 1);
        end
        q1.push_back(8'h34);
        ready = 1'b1;
        tick();
        n = 0;
        while (!h1 && n < 20) begin tick(); n++; end
        chk("halted_set", h1, 1);
        repeat (5) tick();
        chk("halt_addra", addra1, 2);
        chk("halt_no_valid", v1, 0);
        q1.push_back(8'h00);
        sel = 1'b0;
        tick();
        chk("halt_hold_1edge", h1, 1);
        tick();
        chk("halt_clear_2edges", h1, 0);
        x = xf1;
        n = 0;
        while (xf1 != x + 1 && n < 10) begin tick(); n++; end
        chk("halt_exit_switch_xfer", xf1, x + 1);
        q1.push_back(8'h12);
        sel = 1'b1;
        x = xf1;
        n = 0;
        while (addra1 != 8'd1 && n < 30) begin tick(); n++; end
        chk("prog_restart_addra", addra1, 1);
        sel = 1'b0;
        q1.push_back(8'h00);
        n = 0;
        while (xf1 != x + 2 && n < 20) begin tick(); n++; end
        chk("abort_then_switch", xf1, x + 2);
        repeat (3) tick();
        chk("abort_addra", addra1, 1);
        q1.push_back(8'h60);
        sw = 4'b0110;
        n = 0;
        while (!v1 && n < 10) begin tick(); n++; end
        chk("sw_latency_edges", n, 3);
        x = xf1;
        repeat (24) tick();
        chk("sw_no_reissue", xf1, x + 1);
        q1.push_back(8'h70);
        sw = 4'b0111;
        n = 0;
        while (xf1 != x + 2 && n < 10) begin tick(); n++; end
        chk("sw_new_value", xf1, x + 2);
        q2.push_back(8'h00);
        repeat (6) q2.push_back(8'h11);
        rst2 = 1'b0;
        n = 0;
        while (xf2 < 7 && n < 100) begin tick(); n++; end
        rst2 = 1'b1;
        chk("wrap_xfer_count", xf2, 7);
        for (int i = 0; i < 6; i++) chk("wrap_addra_seq", a2_log[i+1], exp_a[i]);
        for (int i = 2; i < 7; i++) chk("wrap_xfer_gap", c2_log[i] - c2_log[i-1], 4);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
